// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared access-size encodings and LSU FSM state type.
package data_mem_pkg;
   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/data_memory_lsu_load_extend.sv
// load_extend: sign- or zero-extends the low 1/2/4 raw load bytes to 64 bits; doubles pass through.
module load_extend
   import data_mem_pkg::*;
(
   input  logic [63:0] raw_i,
   input  size_e       size_i,
   input  logic        uns_i,
   output logic [63:0] data_o
);
   always_comb
      data_o = size_i == SZ_B ? {{56{!uns_i && raw_i[7]}}, raw_i[7:0]} :
               size_i == SZ_H ? {{48{!uns_i && raw_i[15]}}, raw_i[15:0]} :
               size_i == SZ_W ? {{32{!uns_i && raw_i[31]}}, raw_i[31:0]} : raw_i;
endmodule

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressed little-endian data memory behind a single-outstanding
// valid/ready load/store port with fixed response latency and misalign/range error checks.
module data_memory_lsu
   import data_mem_pkg::*;
#(
   parameter int DEPTH_BYTES = 256,
   parameter int LATENCY     = 1,
   parameter int DATA_W      = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [63:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);
   localparam int AW = $clog2(DEPTH_BYTES);

   state_e            state_q;
   logic [1:0]        cnt_q;
   logic [63:0]       addr_q;
   logic [DATA_W-1:0] wdata_q;
   size_e             size_q;
   logic              uns_q;
   logic              write_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic [7:0]        mem [DEPTH_BYTES];

   logic              accept;
   logic              enter_resp;
   logic [63:0]       a;
   logic [DATA_W-1:0] wd;
   size_e             sz;
   logic              un;
   logic              wr;
   logic [3:0]        nbytes;
   logic [64:0]       last;
   logic              err;
   logic [AW-1:0]     base;
   logic [63:0]       raw;
   logic [63:0]       ext;

   assign req_ready  = state_q == IDLE;
   assign resp_valid = state_q == RESP;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // With LATENCY=1 the access completes on the accepting edge, so use the live request fields.
   always_comb begin
      accept     = req_valid && req_ready && !reset;
      enter_resp = (accept && LATENCY == 1) || (state_q == BUSY && cnt_q == 2'd0);
      a          = state_q == IDLE ? req_addr : addr_q;
      wd         = state_q == IDLE ? req_wdata : wdata_q;
      sz         = state_q == IDLE ? size_e'(req_size) : size_q;
      un         = state_q == IDLE ? req_unsigned : uns_q;
      wr         = state_q == IDLE ? req_write : write_q;
      nbytes     = 4'd1 << sz;
      last       = {1'b0, a} + {61'd0, nbytes} - 65'd1;
      err        = (a[2:0] & 3'(nbytes - 4'd1)) != 3'd0 || last >= 65'(DEPTH_BYTES);
      base       = a[AW-1:0];
      for (int k = 0; k < 8; k++)
         raw[8*k +: 8] = mem[base + AW'(k)];
   end

   load_extend u_ext (
      .raw_i  (raw),
      .size_i (sz),
      .uns_i  (un),
      .data_o (ext)
   );

   // Memory is deliberately unreset; contents survive reset.
   always_ff @(posedge clk)
      if (enter_resp && wr && !err)
         for (int k = 0; k < 8; k++)
            if (4'(k) < nbytes) mem[base + AW'(k)] <= wd[8*k +: 8];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= SZ_B;
         uns_q   <= 1'b0;
         write_q <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= size_e'(req_size);
            uns_q   <= req_unsigned;
            write_q <= req_write;
         end
         if (enter_resp) begin
            state_q <= RESP;
            rdata_q <= (err || wr) ? '0 : ext;
            err_q   <= err;
         end else if (accept) begin
            state_q <= BUSY;
            cnt_q   <= 2'(LATENCY - 2);
         end else if (state_q == BUSY)
            cnt_q <= cnt_q - 2'd1;
         else if (state_q == RESP && resp_ready)
            state_q <= IDLE;
      end
   end
endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: drives identical traffic into LATENCY=1 and LATENCY=3 instances and
// checks both every cycle against a byte-array memory model and an accept-age timing model.
module tb_data_memory_lsu;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_ready = 1'b0;
   logic        rdy [2];
   logic        vld [2];
   logic        err_o [2];
   logic [63:0] rdata_o [2];

   int          lat [2] = '{1, 3};
   logic [7:0]  mm [2][DEPTH];
   logic [63:0] exp_rdata [2];
   logic        exp_err [2];
   logic [63:0] seen_rdata [2];
   logic        seen_err [2];
   int          age = 0;
   bit          outstanding = 1'b0;
   int          n_err = 0;
   int          n_chk = 0;

   always #5 clk = ~clk;

   data_memory_lsu #(.DEPTH_BYTES(DEPTH), .LATENCY(1), .DATA_W(64)) u_l1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vld[0]),
      .resp_ready(resp_ready), .resp_rdata(rdata_o[0]), .resp_err(err_o[0])
   );

   data_memory_lsu #(.DEPTH_BYTES(DEPTH), .LATENCY(3), .DATA_W(64)) u_l3 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vld[1]),
      .resp_ready(resp_ready), .resp_rdata(rdata_o[1]), .resp_err(err_o[1])
   );

   task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s lat%0d: got %h expected %h at %0t", nm, lat[d], act, exp, $time);
      end
   endtask

   // Reference: error = misaligned or last byte past the end (no wrap); loads build the value
   // from bytes little-endian then extend arithmetically.
   task automatic model(int d, bit w, logic [1:0] sz, bit uns, logic [63:0] addr, logic [63:0] wdata);
      int nb;
      logic [63:0] v;
      nb = 1 << sz;
      exp_err[d] = (addr % 64'(nb)) != 0 || addr > 64'(DEPTH - nb);
      v = '0;
      if (!exp_err[d])
         for (int k = 0; k < nb; k++)
            if (w) mm[d][int'(addr) + k] = wdata[8*k +: 8];
            else v = v | (64'(mm[d][int'(addr) + k]) << (8 * k));
      if (!w && !exp_err[d] && !uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
      exp_rdata[d] = v;
   endtask

   always @(negedge clk)
      if (!reset)
         for (int d = 0; d < 2; d++) begin
            chk("req_ready", d, 64'(rdy[d]), 64'(!outstanding));
            chk("resp_valid", d, 64'(vld[d]), 64'(outstanding && age >= lat[d]));
            if (outstanding && age >= lat[d]) begin
               chk("resp_rdata", d, rdata_o[d], exp_rdata[d]);
               chk("resp_err", d, 64'(err_o[d]), 64'(exp_err[d]));
               seen_rdata[d] = rdata_o[d];
               seen_err[d] = err_o[d];
            end
         end

   task automatic garbage();
      req_valid = 1'($urandom);
      req_write = 1'($urandom);
      req_size = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
   endtask

   // Called and returns at a negedge; junk on req_* while busy must be ignored.
   task automatic txn(bit w, logic [1:0] sz, bit uns, logic [63:0] addr, logic [63:0] wdata, int hold);
      req_valid = 1'b1;
      req_write = w;
      req_size = sz;
      req_unsigned = uns;
      req_addr = addr;
      req_wdata = wdata;
      @(posedge clk);
      model(0, w, sz, uns, addr, wdata);
      model(1, w, sz, uns, addr, wdata);
      outstanding = 1'b1;
      age = 1;
      repeat (2 + hold) begin
         @(negedge clk);
         garbage();
         @(posedge clk);
         age++;
      end
      @(negedge clk);
      garbage();
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      outstanding = 1'b0;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic lit(string nm, logic [63:0] r, bit e);
      for (int d = 0; d < 2; d++) begin
         chk({nm, "_rdata"}, d, seen_rdata[d], r);
         chk({nm, "_err"}, d, 64'(seen_err[d]), 64'(e));
      end
   endtask

   task automatic reset_state(string nm);
      for (int d = 0; d < 2; d++) begin
         chk({nm, "_ready"}, d, 64'(rdy[d]), 64'd1);
         chk({nm, "_valid"}, d, 64'(vld[d]), 64'd0);
         chk({nm, "_rdata"}, d, rdata_o[d], 64'd0);
         chk({nm, "_err"}, d, 64'(err_o[d]), 64'd0);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_state("rst");
      reset = 1'b0;
      @(negedge clk);
      for (int a = 0; a < DEPTH; a += 8) txn(1'b1, 2'd3, 1'b0, 64'(a), {$urandom, $urandom}, 0);
      txn(1'b1, 2'd3, 1'b0, 64'd8, 64'h1122334455667788, 0);
      txn(1'b0, 2'd3, 1'b0, 64'd8, '0, 1);
      lit("ld_d8", 64'h1122334455667788, 1'b0);
      txn(1'b1, 2'd0, 1'b0, 64'd3, 64'h80, 0);
      txn(1'b0, 2'd0, 1'b0, 64'd3, '0, 0);
      lit("ld_b_signed", 64'hFFFFFFFFFFFFFF80, 1'b0);
      txn(1'b0, 2'd0, 1'b1, 64'd3, '0, 2);
      lit("ld_b_unsigned", 64'h80, 1'b0);
      txn(1'b0, 2'd2, 1'b0, 64'd6, '0, 0);
      lit("ld_w_misalign", 64'd0, 1'b1);
      txn(1'b0, 2'd3, 1'b0, 64'(DEPTH - 4), '0, 0);
      lit("ld_d_range", 64'd0, 1'b1);
      txn(1'b1, 2'd2, 1'b0, 64'd6, {$urandom, $urandom}, 0);
      txn(1'b1, 2'd3, 1'b0, 64'(DEPTH - 4), {$urandom, $urandom}, 0);
      txn(1'b1, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, {$urandom, $urandom}, 0);
      lit("st_d_wrap", 64'd0, 1'b1);
      txn(1'b1, 2'd3, 1'b0, 64'(DEPTH - 8), 64'hCAFEF00DDEADBEEF, 0);
      lit("st_d_top", 64'd0, 1'b0);
      txn(1'b0, 2'd0, 1'b0, 64'(DEPTH - 1), '0, 0);
      lit("ld_b_top", 64'hFFFFFFFFFFFFFFCA, 1'b0);
      for (int a = 0; a < 16; a += 8) txn(1'b0, 2'd3, 1'b0, 64'(a), '0, 0);
      txn(1'b0, 2'd3, 1'b0, 64'd16, '0, 5);
      repeat (300) begin
         logic [1:0] sz;
         logic [63:0] addr;
         int r;
         sz = 2'($urandom);
         r = int'($urandom_range(0, 9));
         addr = r < 8 ? 64'($urandom_range(0, DEPTH + 7)) :
                r == 8 ? {$urandom, $urandom} : 64'($urandom_range(DEPTH - 16, DEPTH + 16));
         if ($urandom_range(0, 3) != 0) addr = addr & ~64'((1 << sz) - 1);
         txn(1'($urandom), sz, 1'($urandom), addr, {$urandom, $urandom}, int'($urandom_range(0, 3)));
      end
      txn(1'b1, 2'd3, 1'b0, 64'd16, 64'hA5A50F0F5A5AF0F0, 0);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size = 2'd3;
      req_unsigned = 1'b0;
      req_addr = 64'd16;
      req_wdata = 64'h0123456789ABCDEF;
      @(posedge clk);
      model(0, 1'b1, 2'd3, 1'b0, 64'd16, 64'h0123456789ABCDEF);
      outstanding = 1'b1;
      age = 1;
      @(negedge clk);
      req_valid = 1'b0;
      #2 reset = 1'b1;
      outstanding = 1'b0;
      #1 reset_state("busy_rst");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      txn(1'b0, 2'd3, 1'b0, 64'd16, '0, 0);
      chk("post_rst_ld", 0, seen_rdata[0], 64'h0123456789ABCDEF);
      chk("post_rst_ld", 1, seen_rdata[1], 64'hA5A50F0F5A5AF0F0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
